// File: rtl/second_counter.sv
// Seconds stage of the watch chain: 1 Hz prescaler, BCD seconds 00-59, minute tick on rollover.
// Latency: first sec1 increment CLK_HZ cycles after RUN entry; min_tick registered, aligned with digits 00.
// Backpressure: none; run=0 freezes prescaler and digits, clr zeroes everything and returns to IDLE.
// Optional feature: define SEC_BLINK_EN to add the registered colon/second indicator output blink.
module second_counter #(
  parameter int CLK_HZ = 50000000,
  parameter int PRE_W  = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clr,
  output logic [3:0] sec_10,
  output logic [3:0] sec1,
  output logic       min_tick,
  output logic       running
`ifdef SEC_BLINK_EN
  ,
  output logic       blink
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(CLK_HZ - 1);

  state_t           state;
  logic [PRE_W-1:0] prescaler;
  logic [PRE_W-1:0] pre_nxt;
  logic             sec_pulse;

  // Prescaler terminal count marks the one edge per second where digits advance.
  assign sec_pulse = (prescaler == PRE_TC);
  assign pre_nxt   = sec_pulse ? '0 : prescaler + 1'b1;

  // Control FSM plus prescaler and BCD digits; counting only on edges where state is RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      prescaler <= '0;
      sec_10    <= 4'd0;
      sec1      <= 4'd0;
      min_tick  <= 1'b0;
      running   <= 1'b0;
    end else if (clr) begin
      // Clear wins over a same-cycle rollover, so no minute tick escapes.
      state     <= IDLE;
      prescaler <= '0;
      sec_10    <= 4'd0;
      sec1      <= 4'd0;
      min_tick  <= 1'b0;
      running   <= 1'b0;
    end else begin
      min_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          // The edge on which run falls still counts; freezing starts next cycle.
          prescaler <= pre_nxt;
          if (sec_pulse) begin
            if (sec1 > 4'd9 || sec_10 > 4'd5) begin
              // Corrupted digits recover to 00 silently.
              sec1   <= 4'd0;
              sec_10 <= 4'd0;
            end else if (sec1 != 4'd9) begin
              sec1 <= sec1 + 4'd1;
            end else if (sec_10 != 4'd5) begin
              sec1   <= 4'd0;
              sec_10 <= sec_10 + 4'd1;
            end else begin
              sec1     <= 4'd0;
              sec_10   <= 4'd0;
              min_tick <= 1'b1;
            end
          end
          if (!run) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        PAUSE: begin
          if (run) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          prescaler <= '0;
          sec_10    <= 4'd0;
          sec1      <= 4'd0;
          running   <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEC_BLINK_EN
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(CLK_HZ / 2);

  // Indicator tracks the first half of each second; frozen in PAUSE because the prescaler is.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink <= 1'b0;
    end else if (clr) begin
      blink <= 1'b0;
    end else begin
      case (state)
        // IDLE always holds prescaler at 0, which is in the first half.
        IDLE:    blink <= run;
        RUN:     blink <= (pre_nxt < PRE_HALF);
        default: blink <= blink;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_second_counter.sv
// Bench for second_counter at CLK_HZ=4: directed time-chain scenarios plus random run/clr traffic.
// Reference keeps a count of RUN edges since the last clear and derives digits from it arithmetically.
// Optional blink output is exercised when SEC_BLINK_EN is defined.
module tb_second_counter;

  localparam int HZ = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] sec_10;
  logic [3:0] sec1;
  logic       min_tick;
  logic       running;
`ifdef SEC_BLINK_EN
  logic       blink;
`endif

  second_counter #(.CLK_HZ(HZ), .PRE_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .clr      (clr),
    .sec_10   (sec_10),
    .sec1     (sec1),
    .min_tick (min_tick),
    .running  (running)
`ifdef SEC_BLINK_EN
    ,
    .blink    (blink)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: mode 0=idle 1=run 2=pause; m_cnt = RUN edges since last clear/reset.
  int m_mode = 0;
  int m_cnt  = 0;
  bit m_tick = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_cnt = 0; m_tick = 1'b0;
    end else if (clr) begin
      m_mode = 0; m_cnt = 0; m_tick = 1'b0;
    end else begin
      m_tick = 1'b0;
      if (m_mode == 1) begin
        m_cnt++;
        if (m_cnt % (60 * HZ) == 0) m_tick = 1'b1;
        if (!run) m_mode = 2;
      end else if (run) begin
        m_mode = 1;
      end
    end
  end

  // Per-cycle comparison against the reference.
  always @(negedge clk) begin
    if (chk_en && rst) begin
      check("m_sec1",     32'(sec1),     32'(((m_cnt / HZ) % 60) % 10));
      check("m_sec_10",   32'(sec_10),   32'(((m_cnt / HZ) % 60) / 10));
      check("m_min_tick", 32'(min_tick), 32'(m_tick));
      check("m_running",  32'(running),  32'(m_mode == 1));
`ifdef SEC_BLINK_EN
      check("m_blink", 32'(blink), 32'(m_mode != 0 && (m_cnt % HZ) < HZ / 2));
`endif
    end
  end

  int r;

  initial begin
    // Reset state.
    cyc(2);
    check("rst_sec1", 32'(sec1), 0);
    check("rst_sec_10", 32'(sec_10), 0);
    check("rst_min_tick", 32'(min_tick), 0);
    check("rst_running", 32'(running), 0);
    rst = 1'b1;
    chk_en = 1'b1;

    // Start: RUN entered on edge 1, first increment CLK_HZ edges later.
    run = 1'b1;
    cyc(1);
    check("start_running", 32'(running), 1);
    check("start_sec1", 32'(sec1), 0);
    cyc(4);
    check("first_inc", 32'(sec1), 1);
    cyc(32);
    check("c36_sec1", 32'(sec1), 9);
`ifdef SEC_BLINK_EN
    check("c36_blink", 32'(blink), 1);
`endif
    cyc(4);
    check("c40_sec_10", 32'(sec_10), 1);
    check("c40_sec1", 32'(sec1), 0);

    // Minute rollover at RUN edge 240.
    cyc(199);
    check("c239_sec_10", 32'(sec_10), 5);
    check("c239_sec1", 32'(sec1), 9);
    check("c239_tick", 32'(min_tick), 0);
`ifdef SEC_BLINK_EN
    check("c239_blink", 32'(blink), 0);
`endif
    cyc(1);
    check("c240_tick", 32'(min_tick), 1);
    check("c240_digits", 32'({sec_10, sec1}), 0);
    cyc(1);
    check("c241_tick", 32'(min_tick), 0);

    // Pause at 03 with prescaler 2; resume continues from 2.
    cyc(12);
    run = 1'b0;
    cyc(20);
    check("pause_sec1", 32'(sec1), 3);
    check("pause_sec_10", 32'(sec_10), 0);
    check("pause_running", 32'(running), 0);
`ifdef SEC_BLINK_EN
    check("pause_blink", 32'(blink), 0);
`endif
    run = 1'b1;
    cyc(2);
    check("resume_sec1_hold", 32'(sec1), 3);
    cyc(1);
    check("resume_sec1", 32'(sec1), 4);

    // Clear coincident with 59->00 rollover suppresses the tick.
    cyc(223);
    check("pre_clr_digits", 32'({sec_10, sec1}), 32'h59);
    clr = 1'b1;
    cyc(1);
    check("clr_digits", 32'({sec_10, sec1}), 0);
    check("clr_tick", 32'(min_tick), 0);
    check("clr_running", 32'(running), 0);
`ifdef SEC_BLINK_EN
    check("clr_blink", 32'(blink), 0);
`endif
    clr = 1'b0;

    // Random run/clr traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      clr = (r < 2);
      if (r >= 92) run = ~run;
      cyc(1);
    end

    // Asynchronous reset mid-count at 27.
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    run = 1'b1;
    cyc(109);
    check("pre_rst_digits", 32'({sec_10, sec1}), 32'h27);
    #2 rst = 1'b0;
    #1;
    check("arst_digits", 32'({sec_10, sec1}), 0);
    check("arst_running", 32'(running), 0);
    check("arst_tick", 32'(min_tick), 0);
`ifdef SEC_BLINK_EN
    check("arst_blink", 32'(blink), 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    cyc(5);
    check("post_rst_sec1", 32'(sec1), 1);
    check("post_rst_sec_10", 32'(sec_10), 0);
    cyc(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
